// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle ARM controller and its datapath: instruction
// fields and ALU flags in, datapath enables and mux selects out.
interface multicycle_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] State;

    // No valid/ready pair exists here: the controller advances exactly one
    // state per clock and the datapath obeys whatever it presents that cycle.
    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, State
    );
    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags and evaluates condition codes.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state, next_state;
    logic [3:0] flags;
    logic       condex, cond_ok;
    logic       is_addsub, flag_upd, rd_pc;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic [1:0] alu_cmd;

    always_comb begin
        case (bus.Cond)
            4'b0000: cond_ok = flags[2];
            4'b0001: cond_ok = ~flags[2];
            4'b0010: cond_ok = flags[1];
            4'b0011: cond_ok = ~flags[1];
            4'b0100: cond_ok = flags[3];
            4'b0101: cond_ok = ~flags[3];
            4'b0110: cond_ok = flags[0];
            4'b0111: cond_ok = ~flags[0];
            4'b1000: cond_ok = flags[1] & ~flags[2];
            4'b1001: cond_ok = ~flags[1] | flags[2];
            4'b1010: cond_ok = (flags[3] == flags[0]);
            4'b1011: cond_ok = (flags[3] != flags[0]);
            4'b1100: cond_ok = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ok = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.Funct[4:1])
            4'b0100: alu_cmd = 2'b00;
            4'b0010: alu_cmd = 2'b01;
            4'b0000: alu_cmd = 2'b10;
            4'b1100: alu_cmd = 2'b11;
            default: alu_cmd = 2'b00;
        endcase
    end

    assign is_addsub = (bus.Funct[4:1] == 4'b0100) || (bus.Funct[4:1] == 4'b0010);
    assign flag_upd  = ((state == EXECUTER) || (state == EXECUTEI)) && bus.Funct[0] && condex;
    assign rd_pc     = (bus.Rd == 4'd15);

    // Flags are read by DECODE of the same instruction before EXECUTE can change them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            flags  <= 4'b0000;
            condex <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                condex <= cond_ok;
            if (flag_upd) begin
                flags[3:2] <= bus.ALUFlags[3:2];
                if (is_addsub)
                    flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_state     = FETCH;
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 2'b00;
        bus.ResultSrc  = 2'b00;
        case (state)
            FETCH: begin
                ir_write      = 1'b1;
                pc_write      = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                next_state    = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                case (bus.Op)
                    2'b00:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                next_state  = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.AdrSrc = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = condex & ~rd_pc;
                pc_write      = condex & rd_pc;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_write  = condex;
            end
            EXECUTER, EXECUTEI: begin
                bus.ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
                bus.ALUControl = alu_cmd;
                next_state     = ALUWB;
            end
            ALUWB: begin
                reg_write = condex & ~rd_pc;
                pc_write  = condex & rd_pc;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                pc_write      = condex;
            end
            default: next_state = FETCH;
        endcase
    end

    assign bus.PCWrite  = pc_write & ~reset;
    assign bus.IRWrite  = ir_write & ~reset;
    assign bus.RegWrite = reg_write & ~reset;
    assign bus.MemWrite = mem_write & ~reset;
    assign bus.ImmSrc   = bus.Op;
    assign bus.RegSrc   = {(bus.Op == 2'b01) & ~bus.Funct[0], (bus.Op == 2'b10)};
    assign bus.State    = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control vectors are queued
// by the instruction driver and checked by an independent negedge monitor.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [19:0] exp_q[$];
    int          n_compared;
    int          n_mismatched;
    int          cyc;

    logic [1:0]  cur_op;
    logic [5:0]  cur_funct;
    logic [3:0]  mflags;

    // Vector layout: state, PCW, IRW, RegW, MemW, AdrSrc, SrcA, SrcB, ALUCtl, ResSrc, ImmSrc, RegSrc
    function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic rgw, input logic mw, input logic adr,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] aluc, input logic [1:0] ress);
        logic [1:0] regsrc;
        regsrc = {(cur_op == 2'b01) && !cur_funct[0], cur_op == 2'b10};
        return {st, pcw, irw, rgw, mw, adr, srca, srcb, aluc, ress, cur_op, regsrc};
    endfunction

    // Architectural condition check on stored NZCV
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        logic [19:0] got, e;
        cyc++;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                   bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc,
                   bus.ImmSrc, bus.RegSrc};
            n_compared++;
            if (got !== e) begin
                n_mismatched++;
                $display("FAIL ctrl cycle %0d: got %05h required %05h (state got %0d req %0d)",
                         cyc, got, e, got[19:16], e[19:16]);
            end
        end
    end

    // Driver: reset for n cycles
    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10));
            @(posedge clk);
            #1;
        end
        reset  = 1'b0;
        mflags = 4'b0000;
    endtask

    // Driver: one instruction; abort_at >= 0 asserts reset during that cycle index
    task automatic run_instr(input logic [31:0] instr, input logic [3:0] aflags, input int abort_at);
        logic [19:0] seq[$];
        logic [19:0] rec;
        logic        pass, rd15, aborted;
        logic [1:0]  op;
        logic [5:0]  fn;
        bus.Cond     = instr[31:28];
        bus.Op       = instr[27:26];
        bus.Funct    = instr[25:20];
        bus.Rd       = instr[15:12];
        bus.ALUFlags = aflags;
        op        = instr[27:26];
        fn        = instr[25:20];
        cur_op    = op;
        cur_funct = fn;
        pass      = cond_pass(instr[31:28], mflags);
        rd15      = (instr[15:12] == 4'hF);
        aborted   = 1'b0;

        seq.push_back(mk(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10));
        seq.push_back(mk(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10));
        case (op)
            2'b00: begin
                seq.push_back(mk(fn[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0,
                                 fn[5] ? 2'b01 : 2'b00, alu_of(fn[4:1]), 2'b00));
                seq.push_back(mk(4'd8, pass && rd15, 0, pass && !rd15, 0, 0, 0, 2'b00, 2'b00, 2'b00));
            end
            2'b01: begin
                seq.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
                if (fn[0]) begin
                    seq.push_back(mk(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
                    seq.push_back(mk(4'd4, pass && rd15, 0, pass && !rd15, 0, 0, 0, 2'b00, 2'b00, 2'b01));
                end else begin
                    seq.push_back(mk(4'd5, 0, 0, 0, pass, 1, 0, 2'b00, 2'b00, 2'b00));
                end
            end
            2'b10: seq.push_back(mk(4'd9, pass, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10));
            default: ;
        endcase

        for (int k = 0; k < seq.size(); k++) begin
            rec = seq[k];
            if (k == abort_at) begin
                reset      = 1'b1;
                rec[15:12] = 4'b0000;
            end
            exp_q.push_back(rec);
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                reset   = 1'b0;
                mflags  = 4'b0000;
                aborted = 1'b1;
                break;
            end
        end

        if (!aborted && op == 2'b00 && fn[0] && pass) begin
            mflags[3:2] = aflags[3:2];
            if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010)
                mflags[1:0] = aflags[1:0];
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  cmds[4];
        int          ab;
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
        reset        = 1'b1;
        bus.Cond     = 4'h0;
        bus.Op       = 2'b00;
        bus.Funct    = 6'h00;
        bus.Rd       = 4'h0;
        bus.ALUFlags = 4'h0;
        cur_op       = 2'b00;
        cur_funct    = 6'h00;
        mflags       = 4'h0;
        @(posedge clk);
        #1;
        hold_reset(2);

        // Directed scenarios
        run_instr(32'hE2802005, 4'h0, -1);   // ADD R2,R0,#5
        run_instr(32'hE0511001, 4'h6, -1);   // SUBS R1,R1,R1 -> Z=1,C=1
        run_instr(32'h0A000000, 4'h0, -1);   // BEQ taken
        run_instr(32'h1A000000, 4'h0, -1);   // BNE not taken
        run_instr(32'hE5903004, 4'h0, -1);   // LDR
        run_instr(32'hE5802080, 4'h0, -1);   // STR
        run_instr(32'h12800000, 4'hF, -1);   // ADDNE with Z=1
        run_instr(32'h0A000000, 4'h0, -1);   // flags still Z=1
        run_instr(32'hE28FF000, 4'h0, -1);   // ADD PC,...
        run_instr(32'hE5802080, 4'h0, 3);    // STR aborted in MEMWR
        run_instr(32'h0A000000, 4'h0, -1);   // flags cleared -> BEQ fails
        run_instr(32'hEC000000, 4'h0, -1);   // Op=11
        run_instr(32'hE591F000, 4'h0, -1);   // LDR PC

        // Randomized instructions
        for (int i = 0; i < 400; i++) begin
            w[31:28] = 4'($urandom_range(0, 15));
            w[27:26] = 2'($urandom_range(0, 3));
            w[25]    = 1'($urandom_range(0, 1));
            w[24:21] = cmds[$urandom_range(0, 3)];
            w[20]    = 1'($urandom_range(0, 1));
            w[19:16] = 4'($urandom_range(0, 15));
            w[15:12] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            w[11:0]  = 12'($urandom_range(0, 4095));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(w, 4'($urandom_range(0, 15)), ab);
        end

        @(negedge clk);
        #1;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARM datapath. One shared memory serves instruction fetch and data access, and one ALU serves PC increment, address generation and execution. A state machine sequences the datapath through fetch, decode, execute, memory and writeback, and the block holds the architectural NZCV flags and evaluates condition codes. It sits beside the datapath inside top and is driven by the Instr fields and ALUFlags.

Parameters:
None. The ISA subset is fixed: ADD, SUB, AND, ORR, LDR, STR and B, all with condition codes.

Ports:
clk  in  1  clock; rising edge
reset  in  1  synchronous, active-high
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (L for memory ops)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  PC register enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
MemWrite  out  1  memory write enable
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
ALUSrcA  out  1  0=RD1 register, 1=PC
ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  out  2  equals Op (00 DP, 01 mem, 10 branch)
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01 and L==0)
State  out  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10 to 15 go to FETCH on the next edge with all enables 0.
- Reset: on a clk edge with reset=1, State becomes FETCH and flags NZCV become 0000. While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Reset asserted mid-instruction aborts it. No write enable is asserted in that cycle.
- All outputs decode combinationally from State, the latched CondEx, Op, Funct and Rd. Any output not listed for a state is 0.
- FETCH: IRWrite=1, PCWrite=1 (unconditional), AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10 (forms PC+8).
  - CondEx is latched at the end of this cycle from Cond and the stored flags.
  - Next state: Op=01 goes to MEMADR. Op=00 goes to EXECUTEI if I=1, else EXECUTER. Op=10 goes to BRANCH. Op=11 goes to FETCH (no operation).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state is MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state is FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Next state is FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 or 01 respectively. Next state is ALUWB.
  - ALUControl from cmd: 0100 gives 00, 0010 gives 01, 0000 gives 10, 1100 gives 11. Any other cmd gives 00.
  - Flags update at the end of the cycle only when S=1 and CondEx=1. N and Z always load from ALUFlags. C and V load only for ADD/SUB.
- ALUWB: ResultSrc=00, RegWrite=CondEx. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state is FETCH.
- Writes to Rd=15 in MEMWB or ALUWB: RegWrite=0 and PCWrite=CondEx instead.
- Condition check (N,Z,C,V are the stored flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) is 1. 1111 is 0.
- The condition is evaluated against the flags before any update by the same instruction.
- Latency in cycles including fetch: DP 4, LDR 5, STR 4, B 3, Op=11 2. A failed condition keeps the same cycle count with the gated enables at 0.

Test Plan:
- Reset held 2 cycles, then released: State=0 and PCWrite=IRWrite=0 during reset. First cycle after release has PCWrite=IRWrite=1, ALUSrcB=10. State sequence for ADD R2,R0,#5 (E2802005) is 0,1,7,8,0, with RegWrite=1 only in state 8.
- SUBS R1,R1,R1 (E0511001) with ALUFlags=0110, then BEQ (0A...): flags become Z=1, C=1. The branch visits 0,1,9 with PCWrite=1 in state 9. The same BNE (1A...) gives PCWrite=0 in state 9.
- LDR R3,[R0,#4] (E5903004): State 0,1,2,3,4. AdrSrc=1 in state 3, ResultSrc=01 and RegWrite=1 in state 4.
- STR R2,[R0,#128] (E5802080): State 0,1,2,5. MemWrite=1 only in state 5, RegSrc=10, never RegWrite.
- ADDNE with Z=1 (1280...): full 4-cycle sequence, RegWrite=0 and flags unchanged. ADD PC,... (E28FF000) in ALUWB gives PCWrite=1, RegWrite=0.
- Reset asserted while in MEMWR: MemWrite=0 in that cycle and State=0 on the next edge. An Op=11 word gives 0,1,0 with no enables after fetch.
